// File: rtl/complete_cdb.sv
// Completion-side CDB arbiter: one holding slot per FU, up to CDBW round-robin broadcasts per cycle.
// Optional same-cycle bypass of empty slots into free lanes when CDB_BYPASS_EN is defined.
module complete_cdb #(
    parameter int unsigned NFU  = 8,
    parameter int unsigned CDBW = 3,
    parameter int unsigned PRW  = 6,
    parameter int unsigned XLEN = 32,
    localparam int unsigned IDXW = $clog2(NFU)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NFU-1:0]       fu_done,
    input  logic [NFU*PRW-1:0]   fu_dest_pr,
    input  logic [NFU*XLEN-1:0]  fu_value,
    output logic [NFU-1:0]       fu_accept,
    output logic [CDBW-1:0]      cdb_valid,
    output logic [CDBW*PRW-1:0]  cdb_tag,
    output logic [CDBW*XLEN-1:0] cdb_value,
    output logic [CDBW*IDXW-1:0] cdb_fu_idx
);

    localparam int unsigned LW = $clog2(CDBW + 1);

    logic [NFU-1:0]  hold_valid;
    logic [PRW-1:0]  hold_pr  [NFU];
    logic [XLEN-1:0] hold_val [NFU];
    logic [IDXW-1:0] rr_ptr;

    logic [NFU-1:0]  grant;
    logic [NFU-1:0]  byp_fu;
    logic [CDBW-1:0] lane_used;
    logic [CDBW-1:0] lane_byp;
    logic [IDXW-1:0] lane_fu [CDBW];
    logic            any_grant;
    logic [IDXW-1:0] last_fu;
    logic [IDXW-1:0] rr_next;

    always_comb begin : grant_sel
        logic [LW-1:0]   n;
        logic [IDXW-1:0] j;
        grant     = '0;
        byp_fu    = '0;
        lane_used = '0;
        lane_byp  = '0;
        any_grant = 1'b0;
        last_fu   = rr_ptr;
        n         = '0;
        j         = '0;
        for (int unsigned k = 0; k < CDBW; k++) begin
            lane_fu[k] = '0;
        end
        for (int unsigned s = 0; s < NFU; s++) begin
            j = IDXW'((32'(rr_ptr) + s) % NFU);
            if (hold_valid[j] && (n < LW'(CDBW))) begin
                grant[j]     = 1'b1;
                lane_used[n] = 1'b1;
                lane_fu[n]   = j;
                any_grant    = 1'b1;
                last_fu      = j;
                n            = n + 1'b1;
            end
        end
`ifdef CDB_BYPASS_EN
        // Empty slots with a fresh result fill leftover lanes; rr_ptr tracks held grants only.
        for (int unsigned s = 0; s < NFU; s++) begin
            j = IDXW'((32'(rr_ptr) + s) % NFU);
            if (!hold_valid[j] && fu_done[j] && (n < LW'(CDBW))) begin
                byp_fu[j]    = 1'b1;
                lane_used[n] = 1'b1;
                lane_byp[n]  = 1'b1;
                lane_fu[n]   = j;
                n            = n + 1'b1;
            end
        end
`endif
        rr_next = IDXW'((32'(last_fu) + 1) % NFU);
    end

    always_comb begin : lane_out
        cdb_valid  = lane_used;
        cdb_tag    = '0;
        cdb_value  = '0;
        cdb_fu_idx = '0;
        for (int unsigned k = 0; k < CDBW; k++) begin
            if (lane_used[k]) begin
                if (lane_byp[k]) begin
                    cdb_tag[k*PRW +: PRW]    = fu_dest_pr[32'(lane_fu[k])*PRW +: PRW];
                    cdb_value[k*XLEN +: XLEN] = fu_value[32'(lane_fu[k])*XLEN +: XLEN];
                end else begin
                    cdb_tag[k*PRW +: PRW]    = hold_pr[lane_fu[k]];
                    cdb_value[k*XLEN +: XLEN] = hold_val[lane_fu[k]];
                end
                cdb_fu_idx[k*IDXW +: IDXW] = lane_fu[k];
            end
        end
    end

    assign fu_accept = ~hold_valid | grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid <= '0;
            rr_ptr     <= '0;
            for (int unsigned i = 0; i < NFU; i++) begin
                hold_pr[i]  <= '0;
                hold_val[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NFU; i++) begin
                // Refill wins over grant-clear so a granted slot can take a new result.
                if (fu_done[i] && fu_accept[i] && !byp_fu[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_pr[i]    <= fu_dest_pr[i*PRW +: PRW];
                    hold_val[i]   <= fu_value[i*XLEN +: XLEN];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            if (any_grant) begin
                rr_ptr <= rr_next;
            end
        end
    end

endmodule

// File: tb/tb_complete_cdb.sv
// Bench for complete_cdb: directed vector table, hand sequences, and randomized queue-based model.
module tb_complete_cdb;

    localparam int NFU  = 8;
    localparam int CDBW = 3;
    localparam int PRW  = 6;
    localparam int XLEN = 32;
    localparam int IDXW = 3;

    logic                 clock;
    logic                 reset;
    logic [NFU-1:0]       fu_done;
    logic [NFU*PRW-1:0]   fu_dest_pr;
    logic [NFU*XLEN-1:0]  fu_value;
    logic [NFU-1:0]       fu_accept;
    logic [CDBW-1:0]      cdb_valid;
    logic [CDBW*PRW-1:0]  cdb_tag;
    logic [CDBW*XLEN-1:0] cdb_value;
    logic [CDBW*IDXW-1:0] cdb_fu_idx;

    complete_cdb dut (
        .clock      (clock),
        .reset      (reset),
        .fu_done    (fu_done),
        .fu_dest_pr (fu_dest_pr),
        .fu_value   (fu_value),
        .fu_accept  (fu_accept),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value),
        .cdb_fu_idx (cdb_fu_idx)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [7:0]  done;
        logic [5:0]  pr_base;
        logic [31:0] val_base;
        logic [2:0]  e_valid;
        logic [17:0] e_tag;
        logic [8:0]  e_idx;
        logic [31:0] e_val0;
        logic [7:0]  e_acc;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic [7:0] done, input int prb, input int valb,
                       input logic [2:0] ev, input int t0, input int t1, input int t2,
                       input int i0, input int i1, input int i2, input int v0,
                       input logic [7:0] acc);
        vec_t v;
        v.rst      = rst;
        v.done     = done;
        v.pr_base  = 6'(prb);
        v.val_base = 32'(valb);
        v.e_valid  = ev;
        v.e_tag    = {6'(t2), 6'(t1), 6'(t0)};
        v.e_idx    = {3'(i2), 3'(i1), 3'(i0)};
        v.e_val0   = 32'(v0);
        v.e_acc    = acc;
        vt.push_back(v);
    endtask

    // Reference model state
    logic [NFU-1:0]  m_valid;
    logic [PRW-1:0]  m_pr  [NFU];
    logic [XLEN-1:0] m_val [NFU];
    int              m_rr;

    task automatic rnd_step(input logic r, input logic [NFU-1:0] d);
        int q[$];
        int n, last, j;
        logic [NFU-1:0]       gnt, byp, ea;
        logic [CDBW-1:0]      ev;
        logic [CDBW*PRW-1:0]  et;
        logic [CDBW*XLEN-1:0] evl;
        logic [CDBW*IDXW-1:0] ei;
        gnt = '0; byp = '0; ev = '0; et = '0; evl = '0; ei = '0; n = 0; last = 0;
        @(negedge clock);
        reset   = r;
        fu_done = d;
        for (int i = 0; i < NFU; i++) begin
            fu_dest_pr[i*PRW +: PRW] = 6'($urandom);
            fu_value[i*XLEN +: XLEN] = $urandom;
        end
        for (int s = 0; s < NFU; s++) begin
            j = (m_rr + s) % NFU;
            if (m_valid[j]) q.push_back(j);
        end
        while (n < CDBW && n < q.size()) begin
            j = q[n];
            gnt[j] = 1'b1;
            ev[n] = 1'b1;
            et[n*PRW +: PRW] = m_pr[j];
            evl[n*XLEN +: XLEN] = m_val[j];
            ei[n*IDXW +: IDXW] = 3'(j);
            last = j;
            n++;
        end
`ifdef CDB_BYPASS_EN
        for (int s = 0; s < NFU; s++) begin
            j = (m_rr + s) % NFU;
            if (n < CDBW && !m_valid[j] && d[j]) begin
                byp[j] = 1'b1;
                ev[n] = 1'b1;
                et[n*PRW +: PRW] = fu_dest_pr[j*PRW +: PRW];
                evl[n*XLEN +: XLEN] = fu_value[j*XLEN +: XLEN];
                ei[n*IDXW +: IDXW] = 3'(j);
                n++;
            end
        end
`endif
        ea = ~m_valid | gnt;
        #1;
        chk("rnd_valid", cdb_valid, ev);
        chk("rnd_tag", cdb_tag, et);
        chk("rnd_value", cdb_value, evl);
        chk("rnd_idx", cdb_fu_idx, ei);
        chk("rnd_accept", fu_accept, ea);
        if (r) begin
            m_valid = '0;
            m_rr = 0;
        end else begin
            for (int i = 0; i < NFU; i++) begin
                if (d[i] && ea[i] && !byp[i]) begin
                    m_valid[i] = 1'b1;
                    m_pr[i] = fu_dest_pr[i*PRW +: PRW];
                    m_val[i] = fu_value[i*XLEN +: XLEN];
                end else if (gnt[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            if (q.size() > 0) m_rr = (last + 1) % NFU;
        end
    endtask

    task automatic raw_reset();
        @(negedge clock);
        reset = 1'b1;
        fu_done = '0;
    endtask

    initial begin
        reset = 1'b1;
        fu_done = '0;
        fu_dest_pr = '0;
        fu_value = '0;
        repeat (2) @(negedge clock);

        // Directed table: outputs expected during each row's cycle, before its edge.
        add(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h01, 5, 'hAA, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b001, 5, 0, 0, 0, 0, 0, 'hAA, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(1, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'hFF, 10, 'h100, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b111, 10, 11, 12, 0, 1, 2, 'h100, 8'h07);
        add(0, 8'h00, 0, 0, 3'b111, 13, 14, 15, 3, 4, 5, 'h103, 8'h3F);
        add(0, 8'h00, 0, 0, 3'b011, 16, 17, 0, 6, 7, 0, 'h106, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h04, 5, 'h200, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h04, 18, 'h300, 3'b001, 7, 0, 0, 2, 0, 0, 'h202, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b001, 20, 0, 0, 2, 0, 0, 'h302, 8'hFF);
        add(1, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h1F, 40, 'h400, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(0, 8'h10, 50, 'h500, 3'b111, 40, 41, 42, 0, 1, 2, 'h400, 8'hE7);
        add(0, 8'h10, 50, 'h500, 3'b011, 43, 44, 0, 3, 4, 0, 'h403, 8'hFF);
        add(0, 8'h00, 0, 0, 3'b001, 54, 0, 0, 4, 0, 0, 'h504, 8'hFF);
        add(0, 8'h1F, 60, 'h600, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
        add(1, 8'h00, 0, 0, 3'b111, 60, 61, 62, 0, 1, 2, 'h600, 8'hE7);
        add(0, 8'h00, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 8'hFF);

`ifndef CDB_BYPASS_EN
        for (int r = 0; r < vt.size(); r++) begin
            @(negedge clock);
            reset = vt[r].rst;
            fu_done = vt[r].done;
            for (int i = 0; i < NFU; i++) begin
                fu_dest_pr[i*PRW +: PRW] = vt[r].pr_base + 6'(i);
                fu_value[i*XLEN +: XLEN] = vt[r].val_base + 32'(i);
            end
            #1;
            chk($sformatf("vec%0d_valid", r), cdb_valid, vt[r].e_valid);
            chk($sformatf("vec%0d_tag", r), cdb_tag, vt[r].e_tag);
            chk($sformatf("vec%0d_idx", r), cdb_fu_idx, vt[r].e_idx);
            chk($sformatf("vec%0d_val0", r), cdb_value[31:0], vt[r].e_val0);
            chk($sformatf("vec%0d_accept", r), fu_accept, vt[r].e_acc);
        end
`endif

        // Bypass latency: empty arbiter, FU3 completes with tag 9.
        raw_reset();
        @(negedge clock);
        reset = 1'b0;
        fu_done = 8'h08;
        fu_dest_pr = '0;
        fu_value = '0;
        fu_dest_pr[3*PRW +: PRW] = 6'd9;
        fu_value[3*XLEN +: XLEN] = 32'h99;
        #1;
`ifdef CDB_BYPASS_EN
        chk("byp_c1_valid", cdb_valid, 3'b001);
        chk("byp_c1_tag", cdb_tag, 18'd9);
        chk("byp_c1_idx", cdb_fu_idx, 9'd3);
`else
        chk("byp_c1_valid", cdb_valid, 3'b000);
        chk("byp_c1_tag", cdb_tag, 18'd0);
`endif
        chk("byp_c1_accept", fu_accept, 8'hFF);
        @(negedge clock);
        fu_done = '0;
        #1;
`ifdef CDB_BYPASS_EN
        chk("byp_c2_valid", cdb_valid, 3'b000);
`else
        chk("byp_c2_valid", cdb_valid, 3'b001);
        chk("byp_c2_tag", cdb_tag, 18'd9);
        chk("byp_c2_value", cdb_value, 96'h99);
        chk("byp_c2_idx", cdb_fu_idx, 9'd3);
`endif

        // Randomized run against the queue-based model.
        raw_reset();
        m_valid = '0;
        m_rr = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r;
            logic [NFU-1:0] d;
            r = ($urandom_range(0, 99) == 0);
            d = 8'($urandom);
            if (c % 500 < 100) d = d & 8'($urandom);
            rnd_step(r, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
